// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared PC-source encoding and stack-pointer width helper for the fetch unit.
package pc_fetch_pkg;
    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_JMP  = 2'd1;
    localparam logic [1:0] PC_CALL = 2'd2;
    localparam logic [1:0] PC_RET  = 2'd3;

    function automatic int sp_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control, ROM and status signals of the fetch unit.
interface pc_fetch_if #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
);
    import pc_fetch_pkg::*;
    logic                          EN, JMP, CALL, RET;
    logic [ADDR_W-1:0]             TARGET, ADDR;
    logic [DATA_W-1:0]             ROM_DATA, INSTR;
    logic                          INSTR_VALID, STACK_OVF, STACK_UNF;
    logic [sp_w(STACK_DEPTH)-1:0]  SP;

    modport master (output EN, JMP, CALL, RET, TARGET, ROM_DATA,
                    input ADDR, INSTR, INSTR_VALID, SP, STACK_OVF, STACK_UNF);
    modport slave  (input EN, JMP, CALL, RET, TARGET, ROM_DATA,
                    output ADDR, INSTR, INSTR_VALID, SP, STACK_OVF, STACK_UNF);
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: small return-address stack; pushes beyond full and pops of empty are ignored.
module lifo_stack
    import pc_fetch_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         top,
    output logic [sp_w(DEPTH)-1:0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int CW = sp_w(DEPTH);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem_q [2**IW];
    logic [WIDTH-1:0] mem_d [2**IW];
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign full   = count_q == CW'(DEPTH);
    assign empty  = count_q == '0;
    assign wr_idx = IW'(count_q);
    assign rd_idx = IW'(count_q - 1'b1);
    assign top    = mem_q[rd_idx];
    assign count  = count_q;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            count_d       = count_q + 1'b1;
        end else if (pop && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) count_q <= '0;
        else     count_q <= count_d;

    // Contents need no reset: they are only read while count is non-zero.
    always_ff @(posedge CLK)
        mem_q <= mem_d;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with jump/call/return, registered instruction fetch and sticky stack flags.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int          ADDR_W      = 4,
    parameter int          DATA_W      = 8,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input logic        CLK,
    input logic        RST,
    pc_fetch_if.slave  bus
);
    localparam int SP_W = sp_w(STACK_DEPTH);
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic              push, pop, full, empty;
    logic [1:0]        sel;
    logic [SP_W-1:0]   count;

    lifo_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .CLK(CLK), .RST(RST), .push(push), .pop(pop), .din(pc_inc),
        .top(top), .count(count), .full(full), .empty(empty)
    );

    always_comb begin
        sel     = bus.RET ? PC_RET : bus.CALL ? PC_CALL : bus.JMP ? PC_JMP : PC_INC;
        pc_inc  = pc_q + 1'b1;
        push    = bus.EN && sel == PC_CALL && !full;
        pop     = bus.EN && sel == PC_RET && !empty;
        // A return on an empty stack falls through to a plain increment.
        pc_d    = !bus.EN ? pc_q :
                  (sel == PC_INC || (sel == PC_RET && empty)) ? pc_inc :
                  sel == PC_RET ? top : bus.TARGET;
        instr_d = bus.EN ? bus.ROM_DATA : instr_q;
        valid_d = bus.EN;
        ovf_d   = ovf_q | (bus.EN && sel == PC_CALL && full);
        unf_d   = unf_q | (bus.EN && sel == PC_RET && empty);
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            pc_q    <= ADDR_W'(RESET_ADDR);
            instr_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end

    assign bus.ADDR        = pc_q;
    assign bus.INSTR       = instr_q;
    assign bus.INSTR_VALID = valid_q;
    assign bus.SP          = count;
    assign bus.STACK_OVF   = ovf_q;
    assign bus.STACK_UNF   = unf_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch, stall, call/return, stack flags, priority, async reset and a wide variant.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_fetch_if #(.ADDR_W(4), .DATA_W(8), .STACK_DEPTH(4)) b ();
    pc_fetch_if #(.ADDR_W(6), .DATA_W(16), .STACK_DEPTH(4)) w ();

    pc_fetch_unit #(.ADDR_W(4), .DATA_W(8), .STACK_DEPTH(4), .RESET_ADDR(0))
        dut (.CLK(clk), .RST(rst), .bus(b));
    pc_fetch_unit #(.ADDR_W(6), .DATA_W(16), .STACK_DEPTH(4), .RESET_ADDR(60))
        dut_w (.CLK(clk), .RST(rst), .bus(w));

    function automatic logic [7:0] rw(input int a);
        logic [3:0] x;
        x = a[3:0];
        return {~x, x};
    endfunction

    function automatic logic [15:0] rw2(input int a);
        logic [5:0] x;
        x = a[5:0];
        return {x, ~x, 4'h9};
    endfunction

    assign b.ROM_DATA = rw(int'(b.ADDR));
    assign w.ROM_DATA = rw2(int'(w.ADDR));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic j, input logic c, input logic r, input int t);
        b.JMP = j; b.CALL = c; b.RET = r; b.TARGET = 4'(t);
    endtask

    initial begin
        b.EN = 0; ctl(0, 0, 0, 0);
        w.EN = 0; w.JMP = 0; w.CALL = 0; w.RET = 0; w.TARGET = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", b.ADDR, 0);
        chk("rst_instr", b.INSTR, 0);
        chk("rst_valid", b.INSTR_VALID, 0);
        chk("rst_sp", b.SP, 0);
        chk("rst_ovf", b.STACK_OVF, 0);
        chk("rst_unf", b.STACK_UNF, 0);
        chk("rst_addr_w", w.ADDR, 60);
        rst = 0;
        b.EN = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("inc_addr", b.ADDR, (i + 1) % 16);
            chk("inc_instr", b.INSTR, rw(i));
            chk("inc_valid", b.INSTR_VALID, 1);
        end
        repeat (5) step();
        chk("pre_stall_addr", b.ADDR, 5);
        b.EN = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", b.ADDR, 5);
            chk("stall_valid", b.INSTR_VALID, 0);
            chk("stall_instr", b.INSTR, rw(4));
        end
        b.EN = 1;
        step();
        chk("resume_addr", b.ADDR, 6);
        chk("resume_instr", b.INSTR, rw(5));
        ctl(1, 0, 0, 3); step();
        chk("jmp_addr", b.ADDR, 3);
        chk("jmp_instr", b.INSTR, rw(6));
        ctl(0, 1, 0, 10); step();
        chk("call_addr", b.ADDR, 10);
        chk("call_sp", b.SP, 1);
        ctl(0, 0, 0, 0); step(); step();
        chk("pre_ret_addr", b.ADDR, 12);
        ctl(0, 0, 1, 0); step();
        chk("ret_addr", b.ADDR, 4);
        chk("ret_sp", b.SP, 0);
        for (int i = 0; i < 4; i++) begin
            ctl(0, 1, 0, 8 + i); step();
            chk("nest_addr", b.ADDR, 8 + i);
            chk("nest_sp", b.SP, i + 1);
        end
        chk("nest_no_ovf", b.STACK_OVF, 0);
        ctl(0, 1, 0, 12); step();
        chk("ovf_flag", b.STACK_OVF, 1);
        chk("ovf_sp", b.SP, 4);
        chk("ovf_addr", b.ADDR, 12);
        ctl(0, 0, 1, 0);
        step(); chk("pop1", b.ADDR, 11); chk("pop1_sp", b.SP, 3);
        step(); chk("pop2", b.ADDR, 10); chk("pop2_sp", b.SP, 2);
        step(); chk("pop3", b.ADDR, 9);  chk("pop3_sp", b.SP, 1);
        step(); chk("pop4", b.ADDR, 5);  chk("pop4_sp", b.SP, 0);
        chk("pop4_no_unf", b.STACK_UNF, 0);
        step();
        chk("unf_flag", b.STACK_UNF, 1);
        chk("unf_addr", b.ADDR, 6);
        chk("unf_sp", b.SP, 0);
        ctl(1, 0, 0, 6); step();
        ctl(0, 1, 0, 0); step();
        chk("prio_setup_addr", b.ADDR, 0);
        chk("prio_setup_sp", b.SP, 1);
        ctl(1, 1, 1, 3); step();
        chk("prio_addr", b.ADDR, 7);
        chk("prio_sp", b.SP, 0);
        ctl(1, 0, 0, 2); step();
        chk("prio_jmp_addr", b.ADDR, 2);
        chk("ovf_sticky", b.STACK_OVF, 1);
        chk("unf_sticky", b.STACK_UNF, 1);
        ctl(0, 1, 0, 9); step();
        chk("mid_call_addr", b.ADDR, 9);
        chk("mid_call_sp", b.SP, 1);
        #2 rst = 1;
        #1;
        chk("arst_addr", b.ADDR, 0);
        chk("arst_instr", b.INSTR, 0);
        chk("arst_valid", b.INSTR_VALID, 0);
        chk("arst_sp", b.SP, 0);
        chk("arst_ovf", b.STACK_OVF, 0);
        chk("arst_unf", b.STACK_UNF, 0);
        #1 rst = 0;
        ctl(0, 0, 0, 0);
        step();
        chk("post_rst_addr", b.ADDR, 1);
        chk("post_rst_instr", b.INSTR, rw(0));
        chk("w_idle_addr", w.ADDR, 60);
        w.EN = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("w_addr", w.ADDR, (61 + i) % 64);
            chk("w_instr", w.INSTR, rw2(60 + i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
